// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
//   Sequential binary-to-BCD converter (shift-and-add-3 / double dabble).
//   Converts one binary bit per clock. Its packed BCD result feeds the
//   per-digit 7-segment decoders.
//
// Parameters
//   WIDTH   binary input width in bits
//   DIGITS  number of BCD digits produced; 10**DIGITS must exceed 2**WIDTH
//
// Ports
//   clk      in   1          clock, all flops on posedge
//   rst_n    in   1          asynchronous active-low reset
//   start    in   1          request a conversion; ignored while busy
//   bin_in   in   WIDTH      binary value, sampled on the accepting edge
//   busy     out  1          conversion in progress
//   done     out  1          one-cycle pulse; bcd_out valid from this cycle
//   bcd_out  out  4*DIGITS   packed BCD result, digit0 in [3:0]
//   neg      out  1          sign of the last result (0 in unsigned builds)
//
// Build option
//   SIGNED_BCD_EN  when defined, bin_in is two's complement: the magnitude is
//                  converted and neg reports the sign. When undefined, bin_in
//                  is unsigned and neg is tied low.
// -----------------------------------------------------------------------------
module bin_to_bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  neg
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // Elaboration-time guard: the digit count must hold every WIDTH-bit value,
    // otherwise the top digit would silently lose its carry.
    function automatic bit range_ok();
        logic [127:0] p10;
        logic [127:0] p2;
        p10 = 128'd1;
        p2  = 128'd1 << WIDTH;
        for (int i = 0; i < DIGITS; i++) begin
            p10 = p10 * 128'd10;
            if (p10 > p2) return 1'b1;
        end
        return 1'b0;
    endfunction

    localparam bit RANGE_OK = range_ok();

    if (!RANGE_OK) begin : g_range_err
        $error("bin_to_bcd_seq: DIGITS too small, need 10**DIGITS > 2**WIDTH");
    end

    logic [1:0]          state;
    logic [WIDTH-1:0]    sh;
    logic [BW-1:0]       acc;
    logic [CW-1:0]       cnt;

    logic [BW-1:0]       acc_adj;
    logic [BW+WIDTH-1:0] both_shifted;
    logic [WIDTH-1:0]    load_val;
    logic                accept;
    logic                finish;

    assign busy   = (state == SHIFT);
    assign done   = (state == DONE);
    assign accept = start && (state != SHIFT);
    assign finish = (state == SHIFT) && (cnt == '0);

    // Add-3 correction on every digit that would overflow past 9 when doubled,
    // then one left shift of the combined {acc, sh} register. The bit shifted
    // out of the top digit is the discarded carry.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        acc_adj = acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
                acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
        end
        both_shifted = {acc_adj, sh} << 1;
    end

`ifdef SIGNED_BCD_EN
    logic neg_pend;
    logic neg_q;

    // Magnitude of a two's complement input; the most-negative value wraps to
    // itself, which read as unsigned is exactly 2**(WIDTH-1).
    assign load_val = bin_in[WIDTH-1] ? (~bin_in + WIDTH'(1)) : bin_in;
    assign neg      = neg_q;

    // The sign is captured at accept but only published with bcd_out, so the
    // outputs never mix the sign of one result with the digits of another.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_pend <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            if (accept) neg_pend <= bin_in[WIDTH-1];
            if (finish) neg_q    <= neg_pend;
        end
    end
`else
    assign load_val = bin_in;
    assign neg      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the scratch registers are reset along with the control state so
        // an aborted conversion leaves nothing behind; they are few flops, not a
        // memory array, so clearing them is cheap.
        if (!rst_n) begin
            state   <= IDLE;
            sh      <= '0;
            acc     <= '0;
            cnt     <= '0;
            bcd_out <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register here samples pre-edge values regardless of order.
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sh    <= load_val;
                        acc   <= '0;
                        cnt   <= CW'(WIDTH - 1);
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    acc <= both_shifted[BW+WIDTH-1:WIDTH];
                    sh  <= both_shifted[WIDTH-1:0];
                    if (cnt == '0) begin
                        bcd_out <= both_shifted[BW+WIDTH-1:WIDTH];
                        state   <= DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
